instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 212 +++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: streams host bytes into 16-bit instruction
// words, writes them to instruction memory and holds the CPU until done.
//
// Parameters:
//   ADDR_W     instruction memory address width (depth 2**ADDR_W words)
// Ports:
//   clock      single clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle pulse, begins a new load from IDLE or DONE
//   in_data    program byte from host (high byte first, then low byte)
//   in_valid   in_data holds a valid byte
//   in_ready   loader accepts a byte this cycle (state-only, no in_valid path)
//   mem_we     instruction memory write strobe (WRITE state only)
//   mem_addr   instruction memory write address
//   mem_wdata  last assembled instruction word
//   cpu_hold   stalls fetch/decode and PC until a load completes
//   done       a full load has completed
//   cksum_err  trailing checksum mismatch, meaningful while done=1
// Build option:
//   LOADER_CHECKSUM_EN  adds a trailing checksum byte (CKSUM state) and a
//                       modulo-256 sum over all accepted bytes; when
//                       undefined, cksum_err is tied to 0.

module instr_mem_loader #(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              cksum_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIGH  = 3'd1,
    S_LOW   = 3'd2,
    S_WRITE = 3'd3,
    S_CKSUM = 3'd4,
    S_DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIGH  = 3'd1,
    S_LOW   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd5
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_hi;
  logic [15:0]       r_wdata;

  logic              w_ready;
  logic              w_xfer;
  logic              w_start_ok;
  logic              w_last;

  // Handshake and control qualifiers
  assign w_xfer     = in_valid & w_ready;
  assign w_last     = (r_addr == LAST_ADDR);
  assign w_start_ok = start &
                      ((r_state == S_IDLE) |
                       (r_state == S_DONE));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HIGH;
      end
      S_HIGH: begin
        if (w_xfer) w_next = S_LOW;
      end
      S_LOW: begin
        if (w_xfer) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (!w_last) begin
          w_next = S_HIGH;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CKSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (w_xfer) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (start) w_next = S_HIGH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode: purely from state so in_ready never sees in_valid
  always_comb begin
    w_ready  = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      S_HIGH:  w_ready = 1'b1;
      S_LOW:   w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM: w_ready = 1'b1;
`endif
      S_WRITE: mem_we = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  assign in_ready  = w_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Address counter: cleared on start, advanced after each
  // non-final write; saturates at the last word within a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
    end else if (r_state == S_WRITE && !w_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Word assembly: high byte staged, word published on low byte
  // so mem_wdata keeps the last complete word outside WRITE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi    <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == S_HIGH && w_xfer) begin
        r_hi <= in_data;
      end
      if (r_state == S_LOW && w_xfer) begin
        r_wdata <= {r_hi, in_data};
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_cksum_err;
  logic [7:0] w_sum_next;

  assign w_sum_next = r_sum + in_data;

  // Modulo-256 sum of every accepted byte; the trailing byte
  // makes a well-formed image sum to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_cksum_err <= 1'b0;
    end else if (w_start_ok) begin
      r_sum       <= '0;
      r_cksum_err <= 1'b0;
    end else if (w_xfer) begin
      r_sum <= w_sum_next;
      if (r_state == S_CKSUM) begin
        r_cksum_err <= (w_sum_next != 8'h00);
      end
    end
  end

  assign cksum_err = r_cksum_err;
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of expected
// memory writes plus state checks around reset, gaps, start and reload.

module tb_instr_mem_loader;

  localparam int AW = 3;
  localparam int NW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          cksum_err;

  instr_mem_loader #(.ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .cksum_err (cksum_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int last_wr  = -1;
  bit gap_chk  = 1'b0;

  logic [AW+15:0] sb[$];
  logic [AW+15:0] sb_e;
  logic [15:0]    prog[NW];

  always @(posedge clock) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe
  always @(negedge clock) begin
    if (!reset && mem_we === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("unexp_wr", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(sb_e[AW+15:16]));
        check("wr_data", 32'(mem_wdata), 32'(sb_e[15:0]));
      end
      if (gap_chk && last_wr >= 0)
        check("wr_spacing", 32'(cyc - last_wr), 32'd3);
      last_wr = cyc;
    end
  end

  // All tasks start and end at #1 after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      check("rdy_tmo", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    last_wr = -1;
  endtask

  task automatic load(input int gap_w,
                      input int start_w,
                      input int nwords);
    int c0;
    for (int w = 0; w < nwords; w++) begin
      sb.push_back({AW'(w), prog[w]});
      send_byte(prog[w][15:8]);
      if (w == gap_w) begin
        in_valid = 1'b0;
        c0 = wr_cnt;
        repeat (5) @(posedge clock);
        #1;
        check("gap_no_we", 32'(wr_cnt), 32'(c0));
        check("gap_ready", 32'(in_ready), 32'd1);
      end
      if (w == start_w) begin
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_ign_addr", 32'(mem_addr), 32'(w));
        check("start_ign_hold", 32'(cpu_hold), 32'd1);
      end
      send_byte(prog[w][7:0]);
    end
  endtask

  task automatic finish_load(input logic [7:0] trail,
                             input bit exp_err);
    @(posedge clock); #1;
`ifdef LOADER_CHECKSUM_EN
    check("cksum_wait", 32'(done), 32'd0);
    send_byte(trail);
`endif
    in_valid = 1'b0;
    check("done", 32'(done), 32'd1);
    check("done_hold", 32'(cpu_hold), 32'd0);
    check("done_addr", 32'(mem_addr), 32'(NW - 1));
    check("wdata_hold", 32'(mem_wdata), 32'(prog[NW-1]));
`ifdef LOADER_CHECKSUM_EN
    check("cksum_err", 32'(cksum_err), 32'(exp_err));
`else
    check("cksum_err", 32'(cksum_err), 32'd0);
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_started();
    check("st_done", 32'(done), 32'd0);
    check("st_hold", 32'(cpu_hold), 32'd1);
    check("st_addr", 32'(mem_addr), 32'd0);
    check("st_cksum", 32'(cksum_err), 32'd0);
    check("st_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cksum", 32'(cksum_err), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_hold", 32'(cpu_hold), 32'd1);

    // Basic load, 0x1001..0x1708; byte sum 0xC0, trailer 0x40
    for (int i = 0; i < NW; i++)
      prog[i] = {8'(8'h10 + i), 8'(8'h01 + i)};
    do_start();
    chk_started();
    gap_chk = 1'b1;
    load(-1, -1, NW);
    finish_load(8'h40, 1'b0);
    gap_chk = 1'b0;

    // Reload with a start pulse in LOW@2 and a gap in word 3
    for (int i = 0; i < NW; i++)
      prog[i] = {8'(8'hA0 + i), 8'(8'h5A ^ i)};
    do_start();
    chk_started();
    load(3, 2, NW);
    finish_load(8'h00, 1'b1);

    // Reset after the write to address 4
    do_start();
    load(-1, -1, 5);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_sb", 32'(sb.size()), 32'd0);
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_done", 32'(done), 32'd0);
    do_start();
    chk_started();
    load(-1, -1, NW);
    finish_load(8'h00, 1'b1);

    // Checksum: 16 data bytes summing to 0x37
    for (int i = 0; i < NW; i++)
      prog[i] = 16'h0000;
    prog[0] = 16'h0037;
    do_start();
    chk_started();
    load(-1, -1, NW);
    finish_load(8'hC9, 1'b0);
    do_start();
    chk_started();
    load(-1, -1, NW);
    finish_load(8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
